int_multiplier: RTL and testbench
=================================

# int_multiplier

Sequential unsigned shift-add multiply-accumulate unit computing `product = multiplicand * multiplier + addend`. It is the inverse companion of the integer divider: it reconstructs a dividend from quotient, divisor and remainder, for on-chip self-check and for a multiply mode behind the same pin-level wrapper. It uses a start/busy/done handshake and processes one multiplier bit per clock.

## Interface

Parameters:
- `WIDTH`, default 8: operand width. The product is 2*WIDTH bits.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new operation. Sampled only in IDLE.
- `multiplicand`, input, WIDTH: unsigned operand A. Captured on an accepted start.
- `multiplier`, input, WIDTH: unsigned operand B. Captured on an accepted start.
- `addend`, input, WIDTH: unsigned operand C, zero-extended. Captured on an accepted start.
- `busy`, output, 1: high while an operation is in progress (RUN state).
- `done`, output, 1: single-cycle pulse when `product` becomes valid.
- `product`, output, 2*WIDTH: result A*B+C. Held stable until the next accepted start.

## Operation

- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - `start`=1 → capture A into a 2*WIDTH shift register, capture B into a WIDTH shift register, load the accumulator with zero-extended C, clear the bit counter, go to RUN.
  - `start`=0 → stay in IDLE.
- RUN, once per cycle:
  - If B_sh[0]=1, acc ← acc + A_sh (2*WIDTH-bit add).
  - Then A_sh ← A_sh << 1, B_sh ← B_sh >> 1, and the counter increments.
  - After exactly WIDTH iterations (counter reaches WIDTH-1 in that cycle), go to DONE.
  - There is no early termination on B_sh==0; latency is fixed.
- DONE: the `product` register is loaded with the final acc, `done`=1 for this one cycle, then return to IDLE.
- Width rule: the maximum result (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W < 2^(2W). The result never overflows, so there is no carry-out port.
- `start` while in RUN or DONE is ignored. It is not queued, and operands are not re-sampled.
- Operand inputs may change freely after the start cycle without affecting the result.
- `product` updates only on the DONE transition. Intermediate accumulator values are never visible on `product`.
- Reset (any state, including mid-RUN):
  - State → IDLE, `busy`=0, `done`=0, `product`=0.
  - Internal accumulator, shift registers and counter are cleared.
  - An in-flight operation is abandoned with no `done` pulse.
- Reset has priority over `start` in the same cycle.

## Timing

- Reset values: `busy`=0, `done`=0, `product`=0.
- Let edge 0 be the edge where `start`=1 is sampled in IDLE.
- `busy`=1 after edges 1..WIDTH, i.e. during WIDTH consecutive cycles.
- `done`=1 and `product` valid in the cycle after edge WIDTH+1. `busy` is 0 in that cycle.
- Latency from start edge to `done`: WIDTH+1 cycles (9 for WIDTH=8).
- Earliest next accepted start: on edge WIDTH+2, when the block is back in IDLE. Throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are never high simultaneously.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Basic: A=13, B=11, C=5, pulse `start` → `done` exactly 9 cycles after the start edge, `product`=148, `busy` high for exactly 8 cycles.
- Extremes: A=255, B=255, C=255 → `product`=65280. Also A=0, B=200, C=7 → 7. Also A=1, B=1, C=0 → 1.
- Divider round-trip: quotient=19, divisor=13, remainder=4 → `product`=251. Repeat over 1000 random triples; result must equal A*B+C each time.
- Start while busy: a second `start` with different operands 3 cycles into RUN → ignored. The first result is unchanged, and only one `done` pulse occurs.
- Reset mid-operation: assert `rst` for 1 cycle at RUN cycle 4 → next cycle `busy`=0, `product`=0, and no `done` pulse. A following start with A=7, B=6, C=0 yields 42 with normal latency.
- Back-to-back: hold `start`=1 continuously → a new operation is accepted every 10 cycles. `product` stays stable between `done` pulses and changes only on each `done` cycle.

Source files
------------

// File: rtl/int_multiplier.sv
// Sequential unsigned shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Each RUN cycle retires one multiplier bit, so latency is fixed regardless of operand values.
module int_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             busy_nxt, done_nxt, load_product;

  assign cnt_last = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Flags are registered from the current state, so they trail the FSM by one cycle.
  always_comb begin
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    load_product = 1'b0;
    case (state)
      S_RUN:  busy_nxt = 1'b1;
      S_DONE: begin
        done_nxt     = 1'b1;
        load_product = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_sh <= {{WIDTH{1'b0}}, multiplicand};
          b_sh <= multiplier;
          acc  <= {{WIDTH{1'b0}}, addend};
          cnt  <= '0;
        end
        S_RUN: begin
          if (b_sh[0]) acc <= acc + a_sh;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (load_product) product <= acc;
    end
  end

endmodule

// File: tb/tb_int_multiplier.sv
// Self-checking bench for int_multiplier: directed cases plus random A*B+C round-trips.
module tb_int_multiplier;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand, multiplier, addend;
  logic           busy, done;
  logic [2*W-1:0] product;

  int n_assert = 0;
  int n_fail   = 0;

  int_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int a, input int b, input int c);
    return a * b + c;
  endfunction

  // One operation from IDLE; observes done timing, busy width and product hold.
  task automatic do_op(input int a, input int b, input int c, input string tag, input bit full);
    int busy_cnt, done_at, done_cnt;
    bit overlap, early_change;
    logic [2*W-1:0] prev;
    @(negedge clk);
    multiplicand = W'(a); multiplier = W'(b); addend = W'(c); start = 1'b1;
    prev = product;
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = W'($urandom); multiplier = W'($urandom); addend = W'($urandom);
    busy_cnt = 0; done_at = 0; done_cnt = 0; overlap = 0; early_change = 0;
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (done_at == 0 && product !== prev) early_change = 1;
    end
    chk({tag, "_product"}, 32'(product), 32'(model(a, b, c)));
    chk({tag, "_latency"}, 32'(done_at), 32'(W + 1));
    if (full) begin
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
      chk({tag, "_product_held"}, 32'(early_change), 32'd0);
    end
  endtask

  initial begin
    int a, b, c, done_cnt;
    logic [W-1:0] qa [0:63];
    logic [W-1:0] qb [0:63];
    logic [W-1:0] qc [0:63];
    logic [2*W-1:0] prev;

    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0; addend = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);

    // Reset wins over start on the same edge.
    @(negedge clk); start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prio_busy", 32'(busy), 32'd0);

    do_op(13, 11, 5, "basic", 1);
    do_op(255, 255, 255, "max", 1);
    do_op(0, 200, 7, "zero_a", 0);
    do_op(1, 1, 0, "one", 0);
    do_op(19, 13, 4, "roundtrip", 0);

    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 255));
      do_op(a, b, c, "random", 0);
    end

    // Second start 3 cycles into RUN is ignored.
    @(negedge clk); multiplicand = 8'd21; multiplier = 8'd17; addend = 8'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); multiplicand = 8'd99; multiplier = 8'd77; addend = 8'd55; start = 1'b1;
    @(negedge clk); start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("busy_start_product", 32'(product), 32'(model(21, 17, 3)));
    chk("busy_start_pulses", 32'(done_cnt), 32'd1);

    // Reset mid-operation abandons the result.
    @(negedge clk); multiplicand = 8'd200; multiplier = 8'd201; addend = 8'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    do_op(7, 6, 0, "after_rst", 1);

    // Back-to-back with start held: accepts at edges 0,10,20,..; done at 9,19,29,..
    @(negedge clk);
    qa[0] = W'($urandom); qb[0] = W'($urandom); qc[0] = W'($urandom);
    multiplicand = qa[0]; multiplier = qb[0]; addend = qc[0]; start = 1'b1;
    prev = product;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      chk("b2b_done", 32'(done), 32'((k % 10) == 9));
      if (done) begin
        chk("b2b_product", 32'(product),
            32'(model(int'(qa[k-9]), int'(qb[k-9]), int'(qc[k-9]))));
        prev = product;
      end else begin
        chk("b2b_product_stable", 32'(product), 32'(prev));
      end
      qa[k+1] = W'($urandom); qb[k+1] = W'($urandom); qc[k+1] = W'($urandom);
      multiplicand = qa[k+1]; multiplier = qb[k+1]; addend = qc[k+1];
    end
    start = 1'b0;
    repeat (12) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
